// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first, repeat_cnt times.
// Define SEQGEN_GAP_EN to insert GAP idle cycles between repetitions.
module sequence_generator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] pat_q;
    logic [CNT_W-1:0] rep_q;
    logic [IDX_W-1:0] idx_q;

    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] rep_d;
    logic [IDX_W-1:0] idx_d;
    logic             last_bit_d;
    logic             last_rep_d;

`ifdef SEQGEN_GAP_EN
    localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [GAP_W-1:0] gap_q;
`else
    // GAP stays a legal parameter in this build but has no effect on timing.
    if (GAP < 0) begin : g_gap_check
        $error("sequence_generator: GAP must be non-negative");
    end
`endif

    if (WIDTH < 2) begin : g_width_check
        $error("sequence_generator: WIDTH must be at least 2");
    end

    always_comb begin
        shift_d    = {shift_q[WIDTH-2:0], 1'b0};
        rep_d      = rep_q - 1'b1;
        idx_d      = idx_q + 1'b1;
        last_bit_d = (idx_q == LAST_IDX);
        last_rep_d = (rep_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
`ifdef SEQGEN_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q <= pattern;
                        pat_q   <= pattern;
                        rep_q   <= repeat_cnt;
                        idx_q   <= '0;
                        state_q <= (repeat_cnt == '0) ? S_DONE : S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    shift_q <= shift_d;
                    idx_q   <= idx_d;
                    if (last_bit_d) begin
                        idx_q <= '0;
                        rep_q <= rep_d;
                        if (last_rep_d) begin
                            state_q <= S_DONE;
                        end else begin
`ifdef SEQGEN_GAP_EN
                            if (GAP > 0) begin
                                state_q <= S_GAP;
                                gap_q   <= '0;
                            end else begin
                                shift_q <= pat_q;
                            end
`else
                            // Reload from the captured copy; the live input may have changed.
                            shift_q <= pat_q;
`endif
                        end
                    end
                end

`ifdef SEQGEN_GAP_EN
                S_GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_SHIFT;
                        shift_q <= pat_q;
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so no input reaches an output combinationally.
    assign out_valid = (state_q == S_SHIFT);
    assign out       = out_valid & shift_q[WIDTH-1];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: expected bits/done are stamped with the cycle they must appear in.
module tb_sequence_generator;

    localparam int W   = 4;
    localparam int C   = 8;
    localparam int GAP = 2;
`ifdef SEQGEN_GAP_EN
    localparam int G = GAP;
`else
    localparam int G = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b1;
    logic [W-1:0] pattern = 4'b1011;
    logic [C-1:0] repeat_cnt = 8'd1;
    logic         out;
    logic         out_valid;
    logic         busy;
    logic         done;

    sequence_generator #(.WIDTH(W), .CNT_W(C), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        bit is_done;
        bit val;
    } item_t;

    item_t exp_q[$];
    int    cyc       = 0;
    int    acc_last  = 1;
    int    done_last = 0;
    int    checks    = 0;
    int    errors    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a request accepted at edge a puts bit i of repetition r
    // at cycle a + r*(W+G) + i and done at a + n*W + (n-1)*G (or a when n == 0).
    task automatic accept(input int a, input logic [W-1:0] pat, input int n);
        item_t it;
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < W; i++) begin
                it.stamp   = a + r * (W + G) + i;
                it.is_done = 1'b0;
                it.val     = pat[W-1-i];
                exp_q.push_back(it);
            end
        end
        it.stamp   = (n == 0) ? a : a + n * W + (n - 1) * G;
        it.is_done = 1'b1;
        it.val     = 1'b0;
        exp_q.push_back(it);
        acc_last  = a;
        done_last = it.stamp;
        $display("request @%0d pattern=%b reps=%0d -> done expected @%0d", a, pat, n, done_last);
    endtask

    task automatic step(input bit st, input logic [W-1:0] pat, input int n, input bit rst);
        @(negedge clk);
        reset      = rst;
        start      = st;
        pattern    = pat;
        repeat_cnt = C'(n);
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[$].stamp > cyc) void'(exp_q.pop_back());
            if (done_last > cyc) done_last = cyc;
        end else if (st && cyc > done_last) begin
            accept(cyc + 1, pat, n);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            bit exp_busy, exp_valid, exp_bit, exp_done, hit;
            exp_busy  = (cyc >= acc_last) && (cyc <= done_last);
            hit       = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
            exp_valid = hit && !exp_q[0].is_done;
            exp_bit   = exp_valid && exp_q[0].val;
            exp_done  = hit && exp_q[0].is_done;
            chk("busy", int'(busy), int'(exp_busy));
            chk("out_valid", int'(out_valid), int'(exp_valid));
            chk("out", int'(out), int'(exp_bit));
            chk("done", int'(done), int'(exp_done));
            if (hit) void'(exp_q.pop_front());
        end
    end

    initial begin
        int target;
        // Reset held for two edges with start high.
        step(1'b1, 4'b1011, 1, 1'b1);
        step(1'b0, 4'b0000, 0, 1'b0);

        // Single pattern, then repeats, then zero count.
        step(1'b1, 4'b1011, 1, 1'b0);
        repeat (8) step(1'b0, 4'b0000, 0, 1'b0);
        step(1'b1, 4'b1011, 3, 1'b0);
        repeat (20) step(1'b0, 4'b1111, 0, 1'b0);
        step(1'b1, 4'b1111, 0, 1'b0);
        repeat (3) step(1'b0, 4'b0000, 0, 1'b0);

        // Start while busy is dropped; start in the DONE cycle is dropped; next one is taken.
        step(1'b1, 4'b1011, 1, 1'b0);
        step(1'b1, 4'b0100, 1, 1'b0);
        while (cyc + 1 < done_last) step(1'b0, 4'b0100, 0, 1'b0);
        step(1'b1, 4'b0100, 2, 1'b0);
        step(1'b1, 4'b0110, 1, 1'b0);
        repeat (12) step(1'b0, 4'b0000, 0, 1'b0);

        // Reset during bit 2 of repetition 1, then a fresh request right after release.
        step(1'b1, 4'b1011, 3, 1'b0);
        target = acc_last + (W + G) + 2;
        while (cyc + 1 < target) step(1'b0, 4'b0000, 0, 1'b0);
        step(1'b0, 4'b0000, 0, 1'b1);
        step(1'b0, 4'b0000, 0, 1'b0);
        step(1'b1, 4'b1011, 1, 1'b0);
        repeat (8) step(1'b0, 4'b0000, 0, 1'b0);

        // Randomized traffic with occasional resets; pattern toggles every cycle.
        for (int t = 0; t < 600; t++) begin
            step($urandom_range(0, 3) == 0, W'($urandom), int'($urandom_range(0, 3)),
                 $urandom_range(0, 79) == 0);
        end

        repeat (40) step(1'b0, 4'b0000, 0, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter: captures a WIDTH-bit pattern and a repeat count on a start strobe, then shifts the pattern out MSB-first, one bit per clock, on a qualified serial line. It is the transmit-side counterpart to the team's serial pattern detectors, and drives their `in` input in loopback benches and in-system self-test. Optional idle gaps separate repetitions.

## Interface
- `WIDTH`, default 4: pattern length in bits; must be ≥ 2.
- `CNT_W`, default 8: width of the repeat count.
- `GAP`, default 2: idle cycles between repetitions (used only with `SEQGEN_GAP_EN`); 0 is legal.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `pattern` input WIDTH: pattern to send; bit WIDTH-1 goes first.
- `repeat_cnt` input CNT_W: number of pattern repetitions.
- `out` output 1: serial data; 0 whenever `out_valid`=0.
- `out_valid` output 1: `out` carries a pattern bit this cycle.
- `busy` output 1: high in SHIFT, GAP and DONE; high means `start` is ignored.
- `done` output 1: one-cycle pulse at the end of a request.

## Operation
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `done`=0. FSM goes to IDLE and all counters clear.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE, `start`=1:
  - Capture `pattern` into the shift register and `repeat_cnt` into the rep counter.
  - If `repeat_cnt`=0, go to DONE. Otherwise go to SHIFT with bit index 0.
- SHIFT:
  - `out_valid`=1 and `out` = current shift-register MSB; shift left each cycle.
  - After bit WIDTH-1, decrement the rep counter.
  - If reps remain: go to GAP (macro defined and GAP>0) or straight back to SHIFT. The pattern is reloaded from the captured copy, not from the live `pattern` input.
  - If no reps remain: go to DONE.
- GAP: `out_valid`=0 and `out`=0 for exactly GAP cycles, then SHIFT.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` in SHIFT, GAP or DONE is dropped, not queued. Input changes while busy have no effect.
- Reset mid-request: at the next edge, return to IDLE with reset values. No `done` pulse and no partial completion. The interrupted request is discarded.
- Counters: bit index is $clog2(WIDTH) bits; rep counter is CNT_W bits with no wrap, since the maximum is 2^CNT_W−1 repetitions.

## Timing
- Latency: `start` sampled at edge k; first bit is on `out` and `out_valid` in the cycle after edge k.
- Bit i of repetition r (0-based) is valid in cycle k+1 + r·(WIDTH+G) + i, where G = GAP with the macro and 0 without.
- `busy` length: high for N·WIDTH + (N−1)·G + 1 cycles for N ≥ 1, and 1 cycle for N=0. The final cycle is the DONE cycle, where `done`=1 and `out_valid`=0.
- Back-to-back requests: the earliest new `start` is accepted in the first IDLE cycle after DONE. Minimum turnaround is one idle cycle.
- All outputs are registered or decoded directly from state registers. There are no combinational paths from inputs to outputs.

## Configuration
- `SEQGEN_GAP_EN` defined: GAP state is present; GAP idle cycles are inserted between repetitions, never after the last one.
- `SEQGEN_GAP_EN` undefined: GAP state and gap counter are not built; the GAP parameter is ignored; repetitions are contiguous.

## Test plan
1. Reset: hold `reset` 2 cycles with `start`=1 → `out`, `out_valid`, `busy`, `done` all 0; no transfer begins until after `reset` deasserts.
2. Single pattern: `pattern`=4'b1011, `repeat_cnt`=1, one-cycle `start` → `out_valid` high 4 cycles with `out`=1,0,1,1; `done` in cycle 5; `busy` high 5 cycles.
3. Repeats, with macro: `repeat_cnt`=3, GAP=2 → 1011, 2 idle cycles, 1011, 2 idle cycles, 1011, then `done`; `busy` high 17 cycles. Without macro: 12 contiguous valid bits; `busy` high 13 cycles.
4. Zero count: `repeat_cnt`=0 → `out_valid` never asserts; `done` in the cycle after `start`; `busy` high 1 cycle.
5. Start while busy: `pattern`=4'b1011 accepted, then `start`=1 with `pattern`=4'b0100 during SHIFT → stream stays 1011; exactly one `done`; next `start` accepted one cycle after `done`.
6. Reset mid-op: assert `reset` during bit 2 of repetition 1 → next cycle all outputs 0, no `done`; a `start` one cycle after `reset` deasserts produces a complete, correct stream.
